// File: rtl/jelly2_data_logger_trigger.sv
// Triggered pre/post-capture logger: ring-buffers NUM channels plus a timestamp,
// freezes after the post-trigger window and reads out oldest-first over Wishbone.
module jelly2_data_logger_trigger #(
  parameter logic [31:0] CORE_ID        = 32'h527a_f003,
  parameter logic [31:0] CORE_VERSION   = 32'h0001_0000,
  parameter int          NUM            = 4,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMER_WIDTH    = 64,
  parameter int          PTR_WIDTH      = 10,
  parameter string       RAM_TYPE       = "block",
  parameter int          WB_ADR_WIDTH   = 8,
  parameter int          WB_DAT_WIDTH   = 32,
  parameter int          WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int          INIT_PRE_SIZE  = 0,
  parameter int          INIT_POST_SIZE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cke,
  input  logic [NUM*DATA_WIDTH-1:0]   s_data,
  input  logic                        s_valid,
  input  logic                        s_trigger,
  input  logic [WB_ADR_WIDTH-1:0]     s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]     s_wb_dat_i,
  input  logic                        s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]     s_wb_sel_i,
  input  logic                        s_wb_stb_i,
  output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
  output logic                        s_wb_ack_o,
  output logic                        busy
);

  localparam int DEPTH  = 2 ** PTR_WIDTH;
  localparam int CW     = PTR_WIDTH + 1;
  localparam int TW     = (TIMER_WIDTH > 0) ? TIMER_WIDTH : 1;
  localparam int DW_ALL = NUM * DATA_WIDTH;
  localparam int RAM_W  = DW_ALL + TW;
  localparam int RD_LAT = (RAM_TYPE == "distributed") ? 1 : 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID   = WB_ADR_WIDTH'('h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_VERSION   = WB_ADR_WIDTH'('h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'('h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'('h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_COUNT     = WB_ADR_WIDTH'('h07);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_PRE_SIZE  = WB_ADR_WIDTH'('h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_POST_SIZE = WB_ADR_WIDTH'('h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TRIG_T0   = WB_ADR_WIDTH'('h0C);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TRIG_T1   = WB_ADR_WIDTH'('h0D);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_READ_DATA = WB_ADR_WIDTH'('h10);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_POL_T0    = WB_ADR_WIDTH'('h18);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_POL_T1    = WB_ADR_WIDTH'('h19);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_POL_DATA  = WB_ADR_WIDTH'('h20);

  logic [2:0]           state_q, state_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        pre_eff_q, pre_eff_d, post_eff_q, post_eff_d;
  logic [CW-1:0]        pre_size_q, pre_size_d, post_size_q, post_size_d;
  logic [CW-1:0]        pre_arm, post_arm, pre_room;
  logic [TW-1:0]        timer_q, trig_time_q, trig_time_d;
  logic                 sw_trig_q, sw_trig_d;
  logic                 arm_q, abort_q, swtrg_q;
  logic                 rd_valid_q;
  logic [RAM_W-1:0]     ram_rd_q, rd_data;
  logic                 ram_we, accept, trig, keep_fetch;
  logic                 wb_wr, ctl_wr, pop, stall, rd_data_adr, data_ok;
  logic [WB_DAT_WIDTH-1:0]   wmask;
  logic [2*WB_DAT_WIDTH-1:0] trig_ext, pol_timer_ext;
  logic [WB_DAT_WIDTH-1:0]   pol_data [NUM];
  logic [RAM_W-1:0]          mem [DEPTH];
  logic                      unused_ok;

  assign accept = s_valid && cke;
  assign busy   = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);

  // Wishbone handshake: only buffer-data reads in DONE wait for the prefetch.
  assign rd_data_adr = (s_wb_adr_i == ADR_READ_DATA) || (s_wb_adr_i == ADR_POL_T0) ||
                       (s_wb_adr_i == ADR_POL_T1) ||
                       ((s_wb_adr_i >= ADR_POL_DATA) &&
                        (s_wb_adr_i < ADR_POL_DATA + WB_ADR_WIDTH'(NUM)));
  assign stall  = s_wb_stb_i && !s_wb_we_i && rd_data_adr && (state_q == ST_DONE) && !rd_valid_q;
  assign s_wb_ack_o = s_wb_stb_i && !stall;
  assign wb_wr  = s_wb_stb_i && s_wb_we_i;
  assign ctl_wr = wb_wr && (s_wb_adr_i == ADR_CONTROL) && s_wb_sel_i[0];
  assign pop    = s_wb_stb_i && !s_wb_we_i && (s_wb_adr_i == ADR_READ_DATA) &&
                  (state_q == ST_DONE) && rd_valid_q && (cnt_q != '0);
  assign data_ok = (state_q == ST_DONE) && rd_valid_q && (cnt_q != '0);

  generate
    for (genvar gi = 0; gi < WB_DAT_WIDTH; gi++) begin : g_wmask
      assign wmask[gi] = s_wb_sel_i[gi / 8];
    end
    for (genvar gi = 0; gi < NUM; gi++) begin : g_pol
      assign pol_data[gi] = WB_DAT_WIDTH'(rd_data[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

  assign pre_size_d  = (wb_wr && s_wb_adr_i == ADR_PRE_SIZE)
                     ? ((pre_size_q & ~wmask[CW-1:0]) | (s_wb_dat_i[CW-1:0] & wmask[CW-1:0]))
                     : pre_size_q;
  assign post_size_d = (wb_wr && s_wb_adr_i == ADR_POST_SIZE)
                     ? ((post_size_q & ~wmask[CW-1:0]) | (s_wb_dat_i[CW-1:0] & wmask[CW-1:0]))
                     : post_size_q;

  always_comb begin
    if (post_size_q == '0)          post_arm = CW'(1);
    else if (post_size_q > DEPTH_C) post_arm = DEPTH_C;
    else                            post_arm = post_size_q;
    pre_room = DEPTH_C - post_arm;
    pre_arm  = (pre_size_q > pre_room) ? pre_room : pre_size_q;
  end

  assign trig = s_trigger || sw_trig_q || swtrg_q;

  // cnt tracks retained samples; in WAIT it sits at pre_eff so POST ends at pre_eff+post_eff.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    pre_eff_d   = pre_eff_q;
    post_eff_d  = post_eff_q;
    trig_time_d = trig_time_q;
    sw_trig_d   = sw_trig_q;
    ram_we      = 1'b0;
    if (arm_q) begin
      state_d    = (pre_arm == '0) ? ST_WAIT : ST_PRE;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      pre_eff_d  = pre_arm;
      post_eff_d = post_arm;
      sw_trig_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PRE: if (accept) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == pre_eff_q) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (swtrg_q) sw_trig_d = 1'b1;
          if (accept) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (trig) begin
              trig_time_d = timer_q;
              sw_trig_d   = 1'b0;
              cnt_d       = cnt_q + 1'b1;
              state_d     = (cnt_d == pre_eff_q + post_eff_q) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: if (accept) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == pre_eff_q + post_eff_q) state_d = ST_DONE;
        end
        default: ;
      endcase
      if (abort_q && busy) state_d = ST_DONE;
    end
    if (state_d == ST_DONE && state_q != ST_DONE) rd_ptr_d = wr_ptr_d - cnt_d[PTR_WIDTH-1:0];
    if (pop && !arm_q) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pre_eff_q   <= '0;
      post_eff_q  <= CW'(1);
      pre_size_q  <= CW'(INIT_PRE_SIZE);
      post_size_q <= CW'(INIT_POST_SIZE);
      timer_q     <= '0;
      trig_time_q <= '0;
      sw_trig_q   <= 1'b0;
      arm_q       <= 1'b0;
      abort_q     <= 1'b0;
      swtrg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      pre_eff_q   <= pre_eff_d;
      post_eff_q  <= post_eff_d;
      pre_size_q  <= pre_size_d;
      post_size_q <= post_size_d;
      trig_time_q <= trig_time_d;
      sw_trig_q   <= sw_trig_d;
      arm_q       <= ctl_wr && s_wb_dat_i[0];
      abort_q     <= ctl_wr && s_wb_dat_i[1];
      swtrg_q     <= ctl_wr && s_wb_dat_i[2];
      if (cke && TIMER_WIDTH > 0) timer_q <= timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr_q] <= {timer_q, s_data};
    ram_rd_q <= mem[rd_ptr_q];
  end

  // The read pipeline continuously follows rd_ptr; rd_valid rises once it has settled.
  assign keep_fetch = (state_q == ST_DONE) && !pop && !arm_q;

  generate
    if (RD_LAT == 1) begin : g_dist
      assign rd_data = ram_rd_q;
      always_ff @(posedge clk) begin
        if (reset) rd_valid_q <= 1'b0;
        else       rd_valid_q <= keep_fetch;
      end
    end else begin : g_block
      logic             fetch_q;
      logic [RAM_W-1:0] dout_q;
      assign rd_data = dout_q;
      always_ff @(posedge clk) begin
        dout_q <= ram_rd_q;
        if (reset) begin
          fetch_q    <= 1'b0;
          rd_valid_q <= 1'b0;
        end else begin
          fetch_q    <= keep_fetch;
          rd_valid_q <= keep_fetch && fetch_q;
        end
      end
    end
  endgenerate

  assign trig_ext      = (2*WB_DAT_WIDTH)'(trig_time_q);
  assign pol_timer_ext = (2*WB_DAT_WIDTH)'(rd_data[RAM_W-1 -: TW]);

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID:   s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      ADR_VERSION:   s_wb_dat_o = WB_DAT_WIDTH'(CORE_VERSION);
      ADR_STATUS:    s_wb_dat_o = WB_DAT_WIDTH'(state_q);
      ADR_COUNT:     s_wb_dat_o = WB_DAT_WIDTH'(cnt_q);
      ADR_PRE_SIZE:  s_wb_dat_o = WB_DAT_WIDTH'(pre_size_q);
      ADR_POST_SIZE: s_wb_dat_o = WB_DAT_WIDTH'(post_size_q);
      ADR_TRIG_T0:   s_wb_dat_o = trig_ext[WB_DAT_WIDTH-1:0];
      ADR_TRIG_T1:   s_wb_dat_o = trig_ext[2*WB_DAT_WIDTH-1:WB_DAT_WIDTH];
      ADR_READ_DATA: s_wb_dat_o = data_ok ? pol_data[0] : '0;
      ADR_POL_T0:    s_wb_dat_o = data_ok ? pol_timer_ext[WB_DAT_WIDTH-1:0] : '0;
      ADR_POL_T1:    s_wb_dat_o = data_ok ? pol_timer_ext[2*WB_DAT_WIDTH-1:WB_DAT_WIDTH] : '0;
      default:       s_wb_dat_o = '0;
    endcase
    for (int i = 0; i < NUM; i++) begin
      if (s_wb_adr_i == ADR_POL_DATA + WB_ADR_WIDTH'(i)) s_wb_dat_o = data_ok ? pol_data[i] : '0;
    end
  end

  assign unused_ok = ^{s_wb_dat_i, wmask, rd_data};

endmodule

// File: tb/tb_jelly2_data_logger_trigger.sv
// Directed bench for the triggered data logger: capture windows, clamping, abort,
// clock-enable gating, reset during capture and ring wrap with readout stall.
module tb_jelly2_data_logger_trigger;
  localparam int NUM = 4, DW = 32, AW = 8, WW = 32, SW = 4;

  logic              clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic [NUM*DW-1:0] s_data = '0;
  logic              s_valid = 1'b0, s_trigger = 1'b0;
  logic [AW-1:0]     adr = '0;
  logic [WW-1:0]     wdat = '0;
  logic              we = 1'b0, stb = 1'b0;
  logic [SW-1:0]     sel = '1;
  logic [WW-1:0]     rdat;
  logic              ack, busy;

  int          checks = 0, passed = 0;
  logic [63:0] tb_timer;
  logic [63:0] stamps [0:1023];

  jelly2_data_logger_trigger #(.PTR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data(s_data), .s_valid(s_valid), .s_trigger(s_trigger),
    .s_wb_adr_i(adr), .s_wb_dat_i(wdat), .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb),
    .s_wb_dat_o(rdat), .s_wb_ack_o(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts clk edges with cke since reset.
  always @(posedge clk) begin
    if (reset) tb_timer <= 64'd0;
    else if (cke) tb_timer <= tb_timer + 64'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    adr = a; wdat = d; we = 1'b1; stb = 1'b1; sel = '1;
    tick();
    stb = 1'b0; we = 1'b0;
    $display("wb wr adr=%02h dat=%08h", a, d);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d, output int stall);
    adr = a; we = 1'b0; stb = 1'b1; stall = 0; d = '0;
    #1;
    while (!ack && stall < 20) begin
      tick(); #1;
      stall++;
    end
    if (!ack) begin
      checks++;
      $display("FAIL wb_read_timeout adr=%02h got no ack after %0d cycles, required ack", a, stall);
    end else begin
      d = rdat;
    end
    @(posedge clk); #1;
    stb = 1'b0;
    $display("wb rd adr=%02h dat=%08h stall=%0d", a, d, stall);
  endtask

  task automatic arm();
    wb_write(8'h04, 32'h1);
    tick();
  endtask

  task automatic abort_capture();
    wb_write(8'h04, 32'h2);
    tick();
  endtask

  task automatic send(input int idx, input logic trg);
    s_data    = {32'(idx + 768), 32'(idx + 512), 32'(idx + 256), 32'(idx)};
    s_valid   = 1'b1;
    s_trigger = trg;
    stamps[idx] = tb_timer;
    tick();
    s_valid   = 1'b0;
    s_trigger = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; int st;
    reset = 1'b1;
    repeat (3) tick();
    adr = 8'h00; we = 1'b0; stb = 1'b1; #1;
    checks++; if (ack !== 1'b1) $display("FAIL reset_ack got %b want 1", ack); else passed++;
    checks++; if (rdat !== 32'h527a_f003) $display("FAIL reset_core_id got %08h want 527af003", rdat); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    stb = 1'b0;
    reset = 1'b0;
    tick();
    wb_read(8'h01, d, st);
    checks++; if (d !== 32'h0001_0000) $display("FAIL reset_version got %08h want 00010000", d); else passed++;
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd0) $display("FAIL reset_status got %0d want 0", d); else passed++;
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd0) $display("FAIL reset_count got %0d want 0", d); else passed++;
    wb_read(8'h08, d, st);
    checks++; if (d !== 32'd0) $display("FAIL reset_pre_size got %0d want 0", d); else passed++;
    wb_read(8'h09, d, st);
    checks++; if (d !== 32'd1) $display("FAIL reset_post_size got %0d want 1", d); else passed++;
    wb_read(8'h0C, d, st);
    checks++; if (d !== 32'd0) $display("FAIL reset_trig_time got %0d want 0", d); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] d; int st;
    wb_write(8'h08, 32'd4);
    wb_write(8'h09, 32'd4);
    arm();
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd1) $display("FAIL basic_status_pre got %0d want 1", d); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else passed++;
    for (int i = 0; i < 20; i++) send(i, i == 10);
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd4) $display("FAIL basic_status_done got %0d want 4", d); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %b want 0", busy); else passed++;
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd8) $display("FAIL basic_count got %0d want 8", d); else passed++;
    wb_read(8'h0C, d, st);
    checks++; if (d !== stamps[10][31:0]) $display("FAIL basic_trig_time0 got %0d want %0d", d, stamps[10][31:0]); else passed++;
    wb_read(8'h0D, d, st);
    checks++; if (d !== stamps[10][63:32]) $display("FAIL basic_trig_time1 got %0d want %0d", d, stamps[10][63:32]); else passed++;
    wb_read(8'h21, d, st);
    checks++; if (d !== 32'd262) $display("FAIL basic_pol_data1 got %0d want 262", d); else passed++;
    wb_read(8'h18, d, st);
    checks++; if (d !== stamps[6][31:0]) $display("FAIL basic_pol_timer0 got %0d want %0d", d, stamps[6][31:0]); else passed++;
    for (int k = 0; k < 8; k++) begin
      wb_read(8'h10, d, st);
      checks++; if (d !== 32'(6 + k)) $display("FAIL basic_pop%0d got %0d want %0d", k, d, 6 + k); else passed++;
    end
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd0) $display("FAIL basic_count_empty got %0d want 0", d); else passed++;
  endtask

  task automatic test_pre_trigger();
    logic [31:0] d; int st;
    arm();
    send(50, 1'b0); send(51, 1'b0); send(52, 1'b1);
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd1) $display("FAIL pretrig_status_pre got %0d want 1", d); else passed++;
    send(53, 1'b0);
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd2) $display("FAIL pretrig_status_wait got %0d want 2", d); else passed++;
    for (int i = 54; i <= 60; i++) send(i, i == 57);
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd8) $display("FAIL pretrig_count got %0d want 8", d); else passed++;
    for (int k = 0; k < 8; k++) begin
      wb_read(8'h10, d, st);
      checks++; if (d !== 32'(53 + k)) $display("FAIL pretrig_pop%0d got %0d want %0d", k, d, 53 + k); else passed++;
    end
  endtask

  task automatic test_clamp();
    logic [31:0] d; int st;
    wb_write(8'h08, 32'd20);
    wb_write(8'h09, 32'd20);
    arm();
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd2) $display("FAIL clamp_status_wait got %0d want 2", d); else passed++;
    for (int i = 100; i <= 120; i++) send(i, i == 105);
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd16) $display("FAIL clamp_count got %0d want 16", d); else passed++;
    for (int k = 0; k < 16; k++) begin
      wb_read(8'h10, d, st);
      checks++; if (d !== 32'(105 + k)) $display("FAIL clamp_pop%0d got %0d want %0d", k, d, 105 + k); else passed++;
    end
  endtask

  task automatic test_abort();
    logic [31:0] d; int st;
    wb_write(8'h08, 32'd4);
    wb_write(8'h09, 32'd4);
    arm();
    send(200, 1'b0); send(201, 1'b0); send(202, 1'b0);
    abort_capture();
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd4) $display("FAIL abort_status got %0d want 4", d); else passed++;
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd3) $display("FAIL abort_count got %0d want 3", d); else passed++;
    for (int k = 0; k < 3; k++) begin
      wb_read(8'h10, d, st);
      checks++; if (d !== 32'(200 + k)) $display("FAIL abort_pop%0d got %0d want %0d", k, d, 200 + k); else passed++;
    end
    wb_read(8'h10, d, st);
    checks++; if (d !== 32'd0) $display("FAIL abort_empty_read got %0d want 0", d); else passed++;
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd0) $display("FAIL abort_empty_count got %0d want 0", d); else passed++;
  endtask

  task automatic test_cke();
    logic [31:0] d, t1, t2; int st;
    arm();
    send(300, 1'b0); send(301, 1'b0);
    cke = 1'b0;
    s_valid = 1'b1; s_data = {4{32'd999}};
    repeat (5) tick();
    s_valid = 1'b0;
    cke = 1'b1;
    send(302, 1'b0);
    abort_capture();
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd3) $display("FAIL cke_count got %0d want 3", d); else passed++;
    wb_read(8'h10, d, st);
    checks++; if (d !== 32'd300) $display("FAIL cke_pop0 got %0d want 300", d); else passed++;
    wb_read(8'h18, t1, st);
    checks++; if (t1 !== stamps[301][31:0]) $display("FAIL cke_stamp301 got %0d want %0d", t1, stamps[301][31:0]); else passed++;
    wb_read(8'h10, d, st);
    checks++; if (d !== 32'd301) $display("FAIL cke_pop1 got %0d want 301", d); else passed++;
    wb_read(8'h18, t2, st);
    checks++; if (t2 !== stamps[301][31:0] + 32'd1) $display("FAIL cke_timer_frozen got %0d want %0d", t2, stamps[301][31:0] + 32'd1); else passed++;
    wb_read(8'h10, d, st);
    checks++; if (d !== 32'd302) $display("FAIL cke_pop2 got %0d want 302", d); else passed++;
  endtask

  task automatic test_reset_post();
    logic [31:0] d; int st;
    arm();
    for (int i = 400; i <= 405; i++) send(i, i == 404);
    checks++; if (busy !== 1'b1) $display("FAIL rstpost_busy_before got %b want 1", busy); else passed++;
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rstpost_busy got %b want 0", busy); else passed++;
    reset = 1'b0;
    tick();
    wb_read(8'h05, d, st);
    checks++; if (d !== 32'd0) $display("FAIL rstpost_status got %0d want 0", d); else passed++;
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd0) $display("FAIL rstpost_count got %0d want 0", d); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] d; int st;
    wb_write(8'h08, 32'd15);
    wb_write(8'h09, 32'd1);
    arm();
    for (int i = 500; i <= 540; i++) send(i, i == 540);
    wb_read(8'h10, d, st);
    checks++; if (st > 2) $display("FAIL wrap_stall got %0d cycles want <=2", st); else passed++;
    checks++; if (d !== 32'd525) $display("FAIL wrap_pop0 got %0d want 525", d); else passed++;
    for (int k = 1; k < 16; k++) begin
      wb_read(8'h10, d, st);
      checks++; if (d !== 32'(525 + k)) $display("FAIL wrap_pop%0d got %0d want %0d", k, d, 525 + k); else passed++;
    end
    wb_read(8'h07, d, st);
    checks++; if (d !== 32'd0) $display("FAIL wrap_count got %0d want 0", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_trigger();
    test_clamp();
    test_abort();
    test_cke();
    test_reset_post();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
